// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller.
//   - register byte offsets from BASE_ADDR
//   - CTRL field positions
//   - hex nibble -> segment table (a..g in bits 0..6)
//   - ctrl_t: the CTRL register contents
package seg7_pkg;

  localparam logic [31:0] OFF_DATA_LO = 32'h0;
  localparam logic [31:0] OFF_DATA_HI = 32'h4;
  localparam logic [31:0] OFF_CTRL    = 32'h8;
  localparam logic [31:0] OFF_DP      = 32'hC;

  localparam int CTRL_MASK_LSB = 0;   // [15:0] digit enable mask
  localparam int CTRL_BR_LSB   = 16;  // [19:16] brightness
  localparam int CTRL_LZS_BIT  = 20;  // leading-zero suppress (optional)

  // Entry [n] is the segment pattern for nibble n.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef struct packed {
    logic [15:0] mask;
    logic [3:0]  bright;
  } ctrl_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register bus for seg7_scan_ctrl.
//   dig_addr  : byte address       (master -> slave)
//   dig_we    : write strobe       (master -> slave)
//   dig_wdata : write data         (master -> slave)
//   dig_rdata : combinational read (slave -> master)
interface seg7_bus_if;
  logic [31:0] dig_addr;
  logic        dig_we;
  logic [31:0] dig_wdata;
  logic [31:0] dig_rdata;

  modport master (output dig_addr, dig_we, dig_wdata, input dig_rdata);
  modport slave  (input dig_addr, dig_we, dig_wdata, output dig_rdata);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit decoder.
//   nib : 4-bit value to display
//   dp  : decimal point
//   seg : a..g in bits 0..6, DP in bit 7, active-high
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  always_comb seg = {dp, HEX_SEG[nib][6:0]};
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner with a small register block.
//   dig_clk / dig_rst : clock, asynchronous active-high reset
//   bus               : seg7_bus_if.slave register port (DATA_LO, DATA_HI,
//                       CTRL, DP at BASE_ADDR + 0x0/0x4/0x8/0xC)
//   dig_en            : one-hot digit select (or zero)
//   dig_dn            : segments a..g + DP
// Each digit owns a slot of FREQ+1 cycles; a free-running 4-bit PWM
// gates the lit time for brightness control.
// Optional: define SEG7_LZ_SUPPRESS_EN to implement CTRL[20] (LZS),
// which blanks leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int          FREQ      = 100,
  parameter int          NDIG      = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000
) (
  input  logic            dig_clk,
  input  logic            dig_rst,
  seg7_bus_if.slave       bus,
  output logic [NDIG-1:0] dig_en,
  output logic [7:0]      dig_dn
);
  // Bits belonging to digits that do not exist are held at zero.
  localparam logic [15:0] DIG_MASK = 16'((32'd1 << NDIG) - 1);
  localparam logic [63:0] NIB_MASK = 64'((65'd1 << (4 * NDIG)) - 1);
  localparam logic [3:0]  LAST     = 4'(NDIG - 1);

  logic [63:0] data;
  logic [15:0] dp;
  ctrl_t       ctrl;
  logic [15:0] cnt;
  logic [3:0]  idx;
  logic [3:0]  pwm;

  logic [31:0] off;
  logic        hit_lo, hit_hi, hit_ctrl, hit_dp;

  always_comb begin
    off      = bus.dig_addr - BASE_ADDR;
    hit_lo   = (off == OFF_DATA_LO);
    hit_hi   = (off == OFF_DATA_HI);
    hit_ctrl = (off == OFF_CTRL);
    hit_dp   = (off == OFF_DP);
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic lzs;
`endif

  // Register block
  always_ff @(posedge dig_clk or posedge dig_rst) begin
    if (dig_rst) begin
      data        <= '0;
      dp          <= '0;
      ctrl.mask   <= DIG_MASK;
      ctrl.bright <= 4'hF;
`ifdef SEG7_LZ_SUPPRESS_EN
      lzs         <= 1'b0;
`endif
    end else if (bus.dig_we) begin
      if (hit_lo)      data[31:0]  <= bus.dig_wdata & NIB_MASK[31:0];
      else if (hit_hi) data[63:32] <= bus.dig_wdata & NIB_MASK[63:32];
      else if (hit_ctrl) begin
        ctrl.mask   <= bus.dig_wdata[CTRL_MASK_LSB +: 16] & DIG_MASK;
        ctrl.bright <= bus.dig_wdata[CTRL_BR_LSB +: 4];
`ifdef SEG7_LZ_SUPPRESS_EN
        lzs         <= bus.dig_wdata[CTRL_LZS_BIT];
`endif
      end
      else if (hit_dp) dp <= bus.dig_wdata[15:0] & DIG_MASK;
    end
  end

  // Scan position and PWM phase; register writes never disturb these.
  always_ff @(posedge dig_clk or posedge dig_rst) begin
    if (dig_rst) begin
      cnt <= 16'(FREQ);
      idx <= '0;
      pwm <= '0;
    end else begin
      pwm <= pwm + 4'd1;
      if (cnt == '0) begin
        cnt <= 16'(FREQ);
        idx <= (idx == LAST) ? 4'd0 : idx + 4'd1;
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  logic suppress;
`ifdef SEG7_LZ_SUPPRESS_EN
  logic [3:0] msnz;  // most-significant non-zero nibble (0 if all zero)
  always_comb begin
    msnz = '0;
    for (int d = 0; d < NDIG; d++)
      if (data[4*d +: 4] != 4'h0) msnz = 4'(d);
    // idx > msnz already excludes digit 0
    suppress = lzs && (idx > msnz) && !dp[idx];
  end
`else
  assign suppress = 1'b0;
`endif

  logic       drive;
  logic [7:0] seg;

  seg7_hex_decode u_dec (
    .nib (data[{idx, 2'b00} +: 4]),
    .dp  (dp[idx]),
    .seg (seg)
  );

  always_comb begin
    drive  = ctrl.mask[idx] && ((ctrl.bright == 4'hF) || (pwm < ctrl.bright))
             && !suppress;
    dig_en = drive ? (NDIG'(1) << idx) : '0;
    dig_dn = drive ? seg : 8'h00;
  end

  // Readback
  always_comb begin
    bus.dig_rdata = '0;
    if (hit_lo)        bus.dig_rdata = data[31:0];
    else if (hit_hi)   bus.dig_rdata = data[63:32];
    else if (hit_ctrl) begin
      bus.dig_rdata[CTRL_MASK_LSB +: 16] = ctrl.mask;
      bus.dig_rdata[CTRL_BR_LSB +: 4]    = ctrl.bright;
`ifdef SEG7_LZ_SUPPRESS_EN
      bus.dig_rdata[CTRL_LZS_BIT]        = lzs;
`endif
    end
    else if (hit_dp)   bus.dig_rdata = {16'h0, dp};
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (FREQ=3, NDIG=4). Keeps a cycle-count model of
// the display: slot = t/(FREQ+1) mod NDIG, pwm = t mod 16, with registers
// held as per-digit arrays. Outputs are compared against it every cycle.
module tb_seg7_scan_ctrl;
  localparam int          F    = 3;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'hFFFF_F000;

  logic         dig_clk = 1'b0;
  logic         dig_rst = 1'b1;
  logic [N-1:0] dig_en;
  logic [7:0]   dig_dn;
  seg7_bus_if   bus ();

  seg7_scan_ctrl #(.FREQ(F), .NDIG(N), .BASE_ADDR(BASE)) dut (
    .dig_clk (dig_clk),
    .dig_rst (dig_rst),
    .bus     (bus),
    .dig_en  (dig_en),
    .dig_dn  (dig_dn)
  );

  always #5 dig_clk = ~dig_clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Behavioural model state
  int         t;
  logic [3:0] m_nib [16];
  logic       m_dp  [16];
  logic       m_en  [16];
  int         m_br;
  logic       m_lzs;

  always @(posedge dig_clk or posedge dig_rst) begin
    if (dig_rst) begin
      t <= 0;
      for (int d = 0; d < 16; d++) begin
        m_nib[d] <= 4'h0;
        m_dp[d]  <= 1'b0;
        m_en[d]  <= (d < N);
      end
      m_br  <= 15;
      m_lzs <= 1'b0;
    end else begin
      t <= t + 1;
      if (bus.dig_we) begin
        case (bus.dig_addr - BASE)
          32'h0: for (int d = 0; d < 8; d++) if (d < N) m_nib[d] <= bus.dig_wdata[4*d +: 4];
          32'h4: for (int d = 8; d < 16; d++) if (d < N) m_nib[d] <= bus.dig_wdata[4*(d-8) +: 4];
          32'h8: begin
            for (int d = 0; d < N; d++) m_en[d] <= bus.dig_wdata[d];
            m_br <= int'(bus.dig_wdata[19:16]);
`ifdef SEG7_LZ_SUPPRESS_EN
            m_lzs <= bus.dig_wdata[20];
`endif
          end
          32'hC: for (int d = 0; d < N; d++) m_dp[d] <= bus.dig_wdata[d];
          default: ;
        endcase
      end
    end
  end

  function automatic int cur_idx();
    return (t / (F + 1)) % N;
  endfunction

  function automatic void model_out(output logic [N-1:0] e_en, output logic [7:0] e_dn);
    int  idx = cur_idx();
    int  top = 0;
    bit  lit;
    for (int d = 0; d < N; d++) if (m_nib[d] != 0) top = d;
    lit = m_en[idx] && (m_br == 15 || (t % 16) < m_br);
    if (m_lzs && idx > top && !m_dp[idx]) lit = 1'b0;
    e_en = lit ? N'(1 << idx) : '0;
    e_dn = lit ? {m_dp[idx], seg_tab[m_nib[idx]][6:0]} : 8'h00;
  endfunction

  function automatic logic [31:0] model_rd(logic [31:0] a);
    logic [31:0] r = '0;
    case (a - BASE)
      32'h0: for (int d = 0; d < 8; d++) if (d < N) r[4*d +: 4] = m_nib[d];
      32'h4: for (int d = 8; d < 16; d++) if (d < N) r[4*(d-8) +: 4] = m_nib[d];
      32'h8: begin
        for (int d = 0; d < N; d++) r[d] = m_en[d];
        r[19:16] = 4'(m_br);
        r[20]    = m_lzs;
      end
      32'hC: for (int d = 0; d < N; d++) r[d] = m_dp[d];
      default: ;
    endcase
    return r;
  endfunction

  // Per-cycle output compare
  always @(negedge dig_clk) begin
    logic [N-1:0] e_en;
    logic [7:0]   e_dn;
    if (chk_on && !dig_rst) begin
      model_out(e_en, e_dn);
      checks++;
      if (dig_en !== e_en || dig_dn !== e_dn) begin
        errors++;
        $display("FAIL scan t=%0d en=%b/%b dn=%h/%h (got/exp)", t, dig_en, e_en, dig_dn, e_dn);
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic wr(logic [31:0] off, logic [31:0] val);
    @(negedge dig_clk);
    bus.dig_addr  = BASE + off;
    bus.dig_wdata = val;
    bus.dig_we    = 1'b1;
    @(negedge dig_clk);
    bus.dig_we    = 1'b0;
  endtask

  task automatic rd_check(string name, logic [31:0] off);
    bus.dig_addr = BASE + off;
    #1;
    check(name, bus.dig_rdata, model_rd(BASE + off));
  endtask

  task automatic wait_slot(int k);
    int n = 0;
    @(negedge dig_clk);
    while (cur_idx() != k && n < 64) begin
      @(negedge dig_clk);
      n++;
    end
    if (n >= 64) check("wait_slot_timeout", 32'(n), 32'd0);
  endtask

  // Count lit cycles and OR of dig_en over the next n cycles.
  task automatic observe(int n, output int lit, output logic [N-1:0] seen);
    lit  = 0;
    seen = '0;
    repeat (n) begin
      @(negedge dig_clk);
      if (dig_en != '0) lit++;
      seen |= dig_en;
    end
  endtask

  logic [7:0] exp_dn [4] = '{8'h06, 8'hF1, 8'h6D, 8'h77};

  initial begin
    int           lit;
    logic [N-1:0] seen;
    logic [31:0]  offs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h24};

    bus.dig_addr  = BASE + 32'h10;
    bus.dig_we    = 1'b0;
    bus.dig_wdata = '0;

    // Reset state
    @(negedge dig_clk);
    check("rst_en", 32'(dig_en), 32'h1);
    check("rst_dn", 32'(dig_dn), 32'h3F);
    rd_check("rst_ctrl", 32'h8);
    check("rst_ctrl_lit", bus.dig_rdata, 32'h000F_000F);
    @(negedge dig_clk);
    dig_rst = 1'b0;
    chk_on  = 1'b1;

    // Slot sequence, 4 cycles per digit
    for (int k = 0; k < 5; k++) begin
      check($sformatf("seq%0d", k), 32'(dig_en), 32'(1 << (k % N)));
      repeat (F + 1) @(negedge dig_clk);
    end

    // Digit content and DP
    wr(32'h0, 32'h0000_A5F1);
    wr(32'hC, 32'h0000_0002);
    for (int k = 0; k < 4; k++) begin
      wait_slot(k);
      check($sformatf("dn_slot%0d", k), 32'(dig_dn), 32'(exp_dn[k]));
    end

    // Mask 0x5: only digits 0 and 2, period unchanged
    wr(32'h8, 32'h000F_0005);
    observe(16, lit, seen);
    check("mask_lit", 32'(lit), 32'd8);
    check("mask_seen", 32'(seen), 32'h5);

    // Brightness 4, then 0
    wr(32'h8, 32'h0004_000F);
    observe(16, lit, seen);
    check("bright4", 32'(lit), 32'd4);
    wr(32'h8, 32'h0000_000F);
    observe(32, lit, seen);
    check("bright0", 32'(lit), 32'd0);

    // Unmapped write and reserved bits
    wr(32'h10, 32'hFFFF_FFFF);
    rd_check("unmapped", 32'h10);
    check("unmapped_lit", bus.dig_rdata, 32'h0);
    rd_check("lo_kept", 32'h0);
    check("lo_kept_lit", bus.dig_rdata, 32'h0000_A5F1);
    wr(32'h8, 32'hFFFF_FFFF);
    rd_check("ctrl_rsvd", 32'h8);
`ifdef SEG7_LZ_SUPPRESS_EN
    check("ctrl_rsvd_lit", bus.dig_rdata, 32'h001F_000F);
    wr(32'hC, 32'h0);
    wr(32'h0, 32'h0000_0012);
    observe(16, lit, seen);
    check("lzs_12", 32'(seen), 32'h3);
    wr(32'h0, 32'h0);
    observe(16, lit, seen);
    check("lzs_0", 32'(seen), 32'h1);
`else
    check("ctrl_rsvd_lit", bus.dig_rdata, 32'h000F_000F);
`endif

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] o = offs[$urandom_range(0, 5)];
      wr(o, $urandom);
      repeat ($urandom_range(0, 5)) @(negedge dig_clk);
      if ($urandom_range(0, 2) == 0) rd_check("rand_rd", offs[$urandom_range(0, 5)]);
    end

    // Reset mid-slot restarts at digit 0 immediately
    wait_slot(2);
    @(posedge dig_clk);
    #2 dig_rst = 1'b1;
    #1;
    check("midrst_en", 32'(dig_en), 32'h1);
    check("midrst_dn", 32'(dig_dn), 32'h3F);
    @(negedge dig_clk);
    dig_rst = 1'b0;
    repeat (8) @(negedge dig_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter FREQ, default 100: scan dwell per digit; each digit slot lasts FREQ+1 dig_clk cycles; legal range 1..65535.
REQ-002 Parameter NDIG, default 8: number of scanned digits; legal range 1..16.
REQ-003 Parameter BASE_ADDR, default 32'hFFFF_F000: byte address of register block; word-aligned.
REQ-004 dig_clk  input  1  clock; all state on rising edge.
REQ-005 dig_rst  input  1  reset, asynchronous, active-high.
REQ-006 dig_addr  input  32  register byte address.
REQ-007 dig_we  input  1  write strobe, one word per cycle.
REQ-008 dig_wdata  input  32  write data.
REQ-009 dig_rdata  output  32  combinational readback of addressed register.
REQ-010 dig_en  output  NDIG  digit select, one-hot or zero, active-high.
REQ-011 dig_dn  output  8  segments a..g in bits 0..6, DP in bit 7, active-high.

Function
REQ-012 Register map SHALL be: +0x0 DATA_LO (nibbles for digits 0..7), +0x4 DATA_HI (digits 8..15), +0x8 CTRL ([15:0] digit enable mask, [19:16] brightness), +0xC DP ([15:0] decimal-point mask).
REQ-013 A write with dig_we=1 and a mapped address SHALL update the register on that edge; unmapped addresses, bits for digits >= NDIG, and reserved bits SHALL be ignored and read as 0.
REQ-014 dig_rdata SHALL return the addressed register; unmapped addresses return 0.
REQ-015 Scan counter SHALL reload FREQ on reaching 0 and increment idx; idx SHALL wrap from NDIG-1 to 0.
REQ-016 Disabled digits (mask bit 0) SHALL still consume their slot with dig_en all-zero, keeping the refresh period at NDIG*(FREQ+1) cycles.
REQ-017 4-bit PWM counter SHALL free-run on dig_clk; the current digit is driven when brightness==15 or pwm < brightness; brightness 0 blanks all digits.
REQ-018 When driven, dig_en SHALL equal 1<<idx and dig_dn SHALL equal hex decode of nibble idx, with bit 7 = DP[idx]; when not driven, dig_en=0 and dig_dn=0.
REQ-019 Hex decode SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
REQ-020 Outputs SHALL be combinational from registered state: a register write appears on outputs the cycle after the write edge; the scan position is unaffected by writes.

Reset
REQ-021 On dig_rst: DATA_LO/HI=0, DP=0, CTRL mask=all ones for NDIG digits, brightness=15, cnt=FREQ, idx=0, pwm=0.
REQ-022 Post-reset outputs SHALL be dig_en=1, dig_dn=8'h3F; reset mid-slot SHALL restart the scan at digit 0 immediately.

Configuration
REQ-023 Macro SEG7_LZ_SUPPRESS_EN defined: CTRL bit 20 (LZS) is implemented; when LZS=1, digits above the most-significant non-zero nibble SHALL be blanked (dig_en=0); digit 0 is always shown; a digit whose DP bit is set is never suppressed.
REQ-024 Macro undefined: CTRL bit 20 reads 0, writes are ignored, and no suppression logic exists.

Structure
REQ-025 Package seg7_pkg SHALL hold register offsets, the CTRL field positions and the hex-to-segment constant table.
REQ-026 Sub-module seg7_hex_decode (4-bit nibble + DP in, 8-bit segments out, combinational) SHALL be instantiated once.

Verification
REQ-027 Reset, FREQ=3, NDIG=4 -> dig_en=0001, dig_dn=3F; idx advances every 4 cycles; dig_en sequence 0001,0010,0100,1000,0001.
REQ-028 Write DATA_LO=0x0000_A5F1, DP=0x2 -> slots show 06, F1 (71|80), 6D, 77.
REQ-029 CTRL mask=0x5 -> dig_en pulses only for digits 0 and 2; the period stays at 16 cycles.
REQ-030 Brightness=4 -> dig_en high exactly 4 of every 16 cycles within a slot; brightness=0 -> dig_en=0 always.
REQ-031 With SEG7_LZ_SUPPRESS_EN, LZS=1, DATA_LO=0x0000_0012 -> only digits 0 and 1 are lit; DATA_LO=0 -> only digit 0 is lit, showing 3F.
REQ-032 Write to BASE+0x10 and read back -> registers are unchanged and dig_rdata=0; dig_rst asserted mid-slot -> dig_en=0001 in the same cycle.
